// File: rtl/pid_multi.sv
// pid_multi: N_CH independent PID loops sharing one signed multiplier; one result per channel per sweep.
// Optional derivative term (MUL_D stage, kd bank, e_prev storage) is built only when PID_DERIV_EN is defined.
module pid_multi #(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int N_CH    = 4,
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    write_enable,
    input  logic [D_WIDTH-1:0]      reg_addr,
    input  logic [D_WIDTH-1:0]      reg_data,
    input  logic                    iterate_enable,
    input  logic [N_CH*D_WIDTH-1:0] target,
    input  logic [N_CH*D_WIDTH-1:0] measurement,
    output logic [D_WIDTH-1:0]      out,
    output logic [CW-1:0]           out_ch,
    output logic                    out_valid,
    output logic                    sweep_done,
    output logic                    busy
);
    localparam int AW = 2*D_WIDTH + 4;
    localparam int PW = 2*D_WIDTH + 2;
    localparam int LW = D_WIDTH - 1;
    localparam logic [CW:0]            N_CH_W  = (CW+1)'(N_CH);
    localparam logic [CW-1:0]          LAST_CH = CW'(N_CH - 1);
    localparam logic signed [AW-1:0]   OUT_MAX = {{(AW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0]   OUT_MIN = ~OUT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_P,
        MUL_I,
`ifdef PID_DERIV_EN
        MUL_D,
`endif
        OUT
    } state_t;

    state_t state_reg, state_next;
    logic [CW-1:0] ch_reg;

    logic signed [D_WIDTH-1:0] kp_mem    [N_CH];
    logic signed [D_WIDTH-1:0] ki_mem    [N_CH];
    logic        [LW-1:0]      lim_mem   [N_CH];
    logic signed [D_WIDTH-1:0] integ_mem [N_CH];
    logic signed [D_WIDTH-1:0] tgt_ch    [N_CH];
    logic signed [D_WIDTH-1:0] meas_ch   [N_CH];

    logic signed [D_WIDTH-1:0] kp_cur_reg, ki_cur_reg, i_reg;
    logic signed [D_WIDTH:0]   e_reg;
    logic signed [AW-1:0]      acc_reg;

`ifdef PID_DERIV_EN
    logic signed [D_WIDTH-1:0] kd_mem     [N_CH];
    logic signed [D_WIDTH:0]   e_prev_mem [N_CH];
    logic signed [D_WIDTH-1:0] kd_cur_reg;
    logic signed [D_WIDTH+1:0] d_reg, d_cur;
`endif

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
        assign tgt_ch[gi]  = target[gi*D_WIDTH +: D_WIDTH];
        assign meas_ch[gi] = measurement[gi*D_WIDTH +: D_WIDTH];
    end

    // Host register decode; limit is an unsigned magnitude clipped to the positive range
    logic [1:0]    wr_field;
    logic [CW-1:0] wr_ch;
    logic          wr_ok;
    logic [LW-1:0] lim_clip;
    logic          unused_addr;
    assign wr_field    = reg_addr[1:0];
    assign wr_ch       = reg_addr[CW+1:2];
    assign wr_ok       = !write_enable && ({1'b0, wr_ch} < N_CH_W);
    assign lim_clip    = reg_data[D_WIDTH-1] ? '1 : reg_data[LW-1:0];
    assign unused_addr = ^reg_addr[D_WIDTH-1:CW+2];

    logic signed [D_WIDTH:0]   e_cur;
    logic signed [D_WIDTH+1:0] i_sum, i_lim, i_neg;
    logic signed [D_WIDTH-1:0] i_clamp;

    always_comb begin
        e_cur = {tgt_ch[ch_reg][D_WIDTH-1], tgt_ch[ch_reg]}
              - {meas_ch[ch_reg][D_WIDTH-1], meas_ch[ch_reg]};
        i_sum = {{2{integ_mem[ch_reg][D_WIDTH-1]}}, integ_mem[ch_reg]} + {e_cur[D_WIDTH], e_cur};
        i_lim = {3'b000, lim_mem[ch_reg]};
        i_neg = -i_lim;
        if (i_sum > i_lim)
            i_clamp = i_lim[D_WIDTH-1:0];
        else if (i_sum < i_neg)
            i_clamp = i_neg[D_WIDTH-1:0];
        else
            i_clamp = i_sum[D_WIDTH-1:0];
    end

`ifdef PID_DERIV_EN
    assign d_cur = {e_cur[D_WIDTH], e_cur} - {e_prev_mem[ch_reg][D_WIDTH], e_prev_mem[ch_reg]};
`endif

    // Shared multiplier: operands are sign-extended to full product width
    logic signed [PW-1:0] mul_a, mul_b, prod;
    logic signed [AW-1:0] prod_ext, acc_next, acc_shift;
    logic signed [D_WIDTH-1:0] u_sat;

    always_comb begin
        mul_a = {{(PW-D_WIDTH){kp_cur_reg[D_WIDTH-1]}}, kp_cur_reg};
        mul_b = {{(PW-D_WIDTH-1){e_reg[D_WIDTH]}}, e_reg};
        case (state_reg)
            MUL_I: begin
                mul_a = {{(PW-D_WIDTH){ki_cur_reg[D_WIDTH-1]}}, ki_cur_reg};
                mul_b = {{(PW-D_WIDTH){i_reg[D_WIDTH-1]}}, i_reg};
            end
`ifdef PID_DERIV_EN
            MUL_D: begin
                mul_a = {{(PW-D_WIDTH){kd_cur_reg[D_WIDTH-1]}}, kd_cur_reg};
                mul_b = {{(PW-D_WIDTH-2){d_reg[D_WIDTH+1]}}, d_reg};
            end
`endif
            default: ;
        endcase
        prod      = mul_a * mul_b;
        prod_ext  = {{(AW-PW){prod[PW-1]}}, prod};
        acc_next  = (state_reg == MUL_P) ? prod_ext : acc_reg + prod_ext;
        acc_shift = acc_reg >>> Q_BITS;
        if (acc_shift > OUT_MAX)
            u_sat = OUT_MAX[D_WIDTH-1:0];
        else if (acc_shift < OUT_MIN)
            u_sat = OUT_MIN[D_WIDTH-1:0];
        else
            u_sat = acc_shift[D_WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (iterate_enable) state_next = LOAD;
            LOAD:    state_next = MUL_P;
            MUL_P:   state_next = MUL_I;
`ifdef PID_DERIV_EN
            MUL_I:   state_next = MUL_D;
            MUL_D:   state_next = OUT;
`else
            MUL_I:   state_next = OUT;
`endif
            OUT:     state_next = (ch_reg == LAST_CH) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg  <= IDLE;
            ch_reg     <= '0;
            kp_cur_reg <= '0;
            ki_cur_reg <= '0;
            i_reg      <= '0;
            e_reg      <= '0;
            acc_reg    <= '0;
            out        <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                kp_mem[i]    <= '0;
                ki_mem[i]    <= '0;
                lim_mem[i]   <= '1;
                integ_mem[i] <= '0;
`ifdef PID_DERIV_EN
                kd_mem[i]     <= '0;
                e_prev_mem[i] <= '0;
`endif
            end
`ifdef PID_DERIV_EN
            kd_cur_reg <= '0;
            d_reg      <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            if (wr_ok) begin
                case (wr_field)
                    2'd0:    kp_mem[wr_ch]  <= reg_data;
                    2'd1:    ki_mem[wr_ch]  <= reg_data;
`ifdef PID_DERIV_EN
                    2'd2:    kd_mem[wr_ch]  <= reg_data;
`endif
                    2'd3:    lim_mem[wr_ch] <= lim_clip;
                    default: ;
                endcase
            end
            case (state_reg)
                IDLE: if (iterate_enable) ch_reg <= '0;
                // Gains are latched here so writes during a sweep only affect later LOADs
                LOAD: begin
                    e_reg             <= e_cur;
                    i_reg             <= i_clamp;
                    integ_mem[ch_reg] <= i_clamp;
                    kp_cur_reg        <= kp_mem[ch_reg];
                    ki_cur_reg        <= ki_mem[ch_reg];
`ifdef PID_DERIV_EN
                    d_reg              <= d_cur;
                    e_prev_mem[ch_reg] <= e_cur;
                    kd_cur_reg         <= kd_mem[ch_reg];
`endif
                end
                MUL_P, MUL_I: acc_reg <= acc_next;
`ifdef PID_DERIV_EN
                MUL_D:        acc_reg <= acc_next;
`endif
                OUT: begin
                    out        <= u_sat;
                    out_ch     <= ch_reg;
                    out_valid  <= 1'b1;
                    sweep_done <= (ch_reg == LAST_CH);
                    if (ch_reg != LAST_CH) ch_reg <= ch_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pid_multi.sv
// Directed self-checking bench for pid_multi (N_CH=4); channel spacing follows PID_DERIV_EN.
`timescale 1ns/1ps
module tb_pid_multi;
    localparam int N = 4;
`ifdef PID_DERIV_EN
    localparam int CYC   = 5;
    localparam int DERIV = 1;
`else
    localparam int CYC   = 4;
    localparam int DERIV = 0;
`endif

    logic        clk = 1'b0;
    logic        rstb, write_enable, iterate_enable;
    logic [15:0] reg_addr, reg_data;
    logic [63:0] target, measurement;
    logic [15:0] out;
    logic [1:0]  out_ch;
    logic        out_valid, sweep_done, busy;

    logic signed [15:0] tgt [N];
    logic signed [15:0] msr [N];

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [15:0] got_out [N];
    int   got_ch  [N];
    int   got_cyc [N];
    logic got_done [N];
    int   got_n;
    logic busy_first, busy_last;
    int   extra;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign target[gi*16 +: 16]      = tgt[gi];
        assign measurement[gi*16 +: 16] = msr[gi];
    end

    pid_multi #(.D_WIDTH(16), .Q_BITS(13), .N_CH(4)) dut (
        .clk(clk), .rstb(rstb), .write_enable(write_enable), .reg_addr(reg_addr),
        .reg_data(reg_data), .iterate_enable(iterate_enable), .target(target),
        .measurement(measurement), .out(out), .out_ch(out_ch), .out_valid(out_valid),
        .sweep_done(sweep_done), .busy(busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int field, input logic [15:0] data);
        @(negedge clk);
        write_enable = 1'b0;
        reg_addr     = 16'(ch*4 + field);
        reg_data     = data;
        @(negedge clk);
        write_enable = 1'b1;
    endtask

    // One sweep: records every out_valid and checks channel order, timing and sweep_done
    task automatic run_sweep(input string tag, input bit hold_ie, input int wr_cyc,
                             input logic [15:0] wr_addr, input logic [15:0] wr_dat);
        got_n = 0; busy_first = 1'b0; busy_last = 1'b1;
        @(negedge clk);
        iterate_enable = 1'b1;
        @(negedge clk);
        if (!hold_ie) iterate_enable = 1'b0;
        for (int cyc = 1; cyc <= 64 && got_n < N; cyc++) begin
            @(negedge clk);
            write_enable = (cyc == wr_cyc) ? 1'b0 : 1'b1;
            if (cyc == wr_cyc) begin reg_addr = wr_addr; reg_data = wr_dat; end
            if (hold_ie && cyc == CYC*N - 1) iterate_enable = 1'b0;
            if (cyc == 1) busy_first = busy;
            if (out_valid) begin
                got_out[got_n] = out; got_ch[got_n] = out_ch;
                got_cyc[got_n] = cyc; got_done[got_n] = sweep_done;
                got_n++;
                if (got_n == N) busy_last = busy;
            end
        end
        write_enable = 1'b1; iterate_enable = 1'b0;
        check({tag, "_count"}, got_n, N);
        check({tag, "_busy_start"}, busy_first, 1);
        check({tag, "_busy_end"}, busy_last, 0);
        for (int c = 0; c < got_n; c++) begin
            check($sformatf("%s_ch%0d_idx", tag, c), got_ch[c], c);
            check($sformatf("%s_ch%0d_cyc", tag, c), got_cyc[c], CYC*(c+1));
            check($sformatf("%s_ch%0d_done", tag, c), got_done[c], (c == N-1) ? 1 : 0);
        end
        $display("[TB] sweep %s outs %0d %0d %0d %0d", tag, got_out[0], got_out[1], got_out[2], got_out[3]);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0; write_enable = 1'b1; iterate_enable = 1'b0;
        reg_addr = '0; reg_data = '0;
        for (int c = 0; c < N; c++) begin tgt[c] = 0; msr[c] = 0; end
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", sweep_done, 0);
        check("rst_busy", busy, 0);
        rstb = 1'b1;

        // Proportional on ch1
        wr(1, 0, 16'h2000);
        tgt[1] = 100; msr[1] = 40;
        run_sweep("prop", 0, 0, '0, '0);
        check("prop_out0", got_out[0], 0);
        check("prop_out1", got_out[1], 60);
        check("prop_out2", got_out[2], 0);
        check("prop_out3", got_out[3], 0);
        tgt[1] = 0; msr[1] = 0;

        // Integral with limit on ch0
        wr(0, 1, 16'h2000);
        wr(0, 3, 16'd100);
        tgt[0] = 60; msr[0] = 0;
        run_sweep("int1", 0, 0, '0, '0);  check("int1_out0", got_out[0], 60);
        run_sweep("int2", 0, 0, '0, '0);  check("int2_out0", got_out[0], 100);
        run_sweep("int3", 0, 0, '0, '0);  check("int3_out0", got_out[0], 100);
        msr[0] = 90;
        run_sweep("int4", 0, 0, '0, '0);  check("int4_out0", got_out[0], 70);
        wr(0, 3, 16'hFFFF);
        tgt[0] = 100; msr[0] = 0;
        run_sweep("limclip", 0, 0, '0, '0); check("limclip_out0", got_out[0], 170);
        wr(0, 3, 16'd50);
        tgt[0] = 0;
        run_sweep("limlow", 0, 0, '0, '0);  check("limlow_out0", got_out[0], 50);

        // Output saturation and floor rounding on ch2
        wr(2, 0, 16'h7FFF);
        tgt[2] = 20000;
        run_sweep("satp", 0, 0, '0, '0);  check("satp_out2", got_out[2], 32767);
        tgt[2] = -20000;
        run_sweep("satn", 0, 0, '0, '0);  check("satn_out2", got_out[2], -32768);
        tgt[2] = 1000;
        run_sweep("flrp", 0, 0, '0, '0);  check("flrp_out2", got_out[2], 3999);
        tgt[2] = -1000;
        run_sweep("flrn", 0, 0, '0, '0);  check("flrn_out2", got_out[2], -4000);
        tgt[2] = 0;

        // Derivative on ch3 (zero when the derivative path is not built)
        wr(3, 2, 16'h2000);
        tgt[3] = 10;
        run_sweep("der1", 0, 0, '0, '0);  check("der1_out3", got_out[3], 10*DERIV);
        tgt[3] = 30;
        run_sweep("der2", 0, 0, '0, '0);  check("der2_out3", got_out[3], 20*DERIV);
        wr(3, 2, 16'h0000);

        // Write ch3 kp during ch0 MUL_I, iterate_enable held high while busy
        tgt[3] = 5;
        run_sweep("wrbusy", 1, 2, 16'(3*4 + 0), 16'h2000);
        check("wrbusy_out3", got_out[3], 5);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) extra++;
        end
        check("no_restart", extra, 0);

        // Reset during channel 1 MUL_P
        @(negedge clk); iterate_enable = 1'b1;
        @(negedge clk); iterate_enable = 1'b0;
        repeat (CYC) @(negedge clk);
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_out", $signed(out), 50);
        @(negedge clk);
        check("mid_pre_busy", busy, 1);
        rstb = 1'b0;
        #1;
        check("mid_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", sweep_done, 0);
        check("mid_out", out, 0);
        check("mid_out_ch", out_ch, 0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        run_sweep("post", 0, 0, '0, '0);
        for (int c = 0; c < N; c++) check($sformatf("post_out%0d", c), got_out[c], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
